// File: rtl/sbn_loader.sv
// sbn_loader: byte-stream program loader for the SBN machine.
//
// Accepts framed bytes over a valid/ready link, assembles instruction and
// data words, writes them through one write port per memory, and gates the
// core with cpu_run. Frame: SYNC(0xA5) CMD [ADDR LEN DATA...] CSUM.
//   CMD 0x01 imem load, 0x02 dmem load, 0x03 run, 0x04 halt.
//   LEN is word count minus one. Word bytes arrive MSB first.
//   (CMD + ADDR + LEN + DATA + CSUM) mod 256 must be zero.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous reset, active low
//   rx_data     incoming byte
//   rx_valid    rx_data valid
//   rx_ready    loader accepts byte (always 1 out of reset)
//   imem_we     imem write strobe, one cycle per word
//   imem_addr   imem write address
//   imem_wdata  imem write data (4*FWIDTH bits)
//   dmem_we     dmem write strobe, one cycle per word
//   dmem_addr   dmem write address
//   dmem_wdata  dmem write data
//   cpu_run     1 lets the core execute, 0 holds it
//   busy        high whenever a frame is being parsed
//   frame_ok    one-cycle pulse after a frame with a good checksum
//   err_code    last frame result: 0 ok, 1 bad cmd, 2 checksum, 3 load while running
module sbn_loader #(
  parameter int unsigned FWIDTH = 8,
  parameter int unsigned DWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [FWIDTH-1:0]     imem_addr,
  output logic [4*FWIDTH-1:0]   imem_wdata,
  output logic                  dmem_we,
  output logic [FWIDTH-1:0]     dmem_addr,
  output logic [DWIDTH-1:0]     dmem_wdata,
  output logic                  cpu_run,
  output logic                  busy,
  output logic                  frame_ok,
  output logic [1:0]            err_code
);

  localparam int unsigned IWIDTH = 4 * FWIDTH;
  localparam int unsigned IBYTES = (IWIDTH + 7) / 8;
  localparam int unsigned DBYTES = (DWIDTH + 7) / 8;
  localparam int unsigned MAXB   = (IBYTES > DBYTES) ? IBYTES : DBYTES;
  // Shift register wide enough for the longer word; bytes older than the
  // current word fall off the top or sit above the word width, so no clear
  // is needed between words.
  localparam int unsigned SW     = 8 * MAXB;

  localparam logic [1:0] ILAST = 2'(IBYTES - 1);
  localparam logic [1:0] DLAST = 2'(DBYTES - 1);

  localparam logic [7:0] SYNC     = 8'hA5;
  localparam logic [7:0] CMD_ILD  = 8'h01;
  localparam logic [7:0] CMD_DLD  = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;
  localparam logic [7:0] CMD_HALT = 8'h04;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StLen,
    StData,
    StCsum
  } state_e;

  state_e state_q, state_d;

  logic              ready_q;
  logic [2:0]        cmd_q, cmd_d;
  logic [FWIDTH-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [SW-1:0]     sh_q, sh_d;

  logic              imem_we_q, imem_we_d;
  logic [FWIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [IWIDTH-1:0] imem_wdata_q, imem_wdata_d;
  logic              dmem_we_q, dmem_we_d;
  logic [FWIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [DWIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
  logic              run_q, run_d;
  logic              ok_q, ok_d;
  logic [1:0]        err_q, err_d;

  logic              xfer;
  logic              is_dmem;
  logic              is_load;
  logic [1:0]        last_byte;
  logic [SW-1:0]     sh_next;
  logic [7:0]        csum_total;

  assign xfer       = rx_valid & ready_q;
  assign is_dmem    = (cmd_q == CMD_DLD[2:0]);
  assign is_load    = (cmd_q == CMD_ILD[2:0]) || (cmd_q == CMD_DLD[2:0]);
  assign last_byte  = is_dmem ? DLAST : ILAST;
  assign sh_next    = (sh_q << 8) | SW'(rx_data);
  assign csum_total = sum_q + rx_data;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    sum_d        = sum_q;
    sh_d         = sh_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    run_d        = run_q;
    ok_d         = 1'b0;
    err_d        = err_q;

    if (xfer) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == SYNC) state_d = StCmd;
        end
        StCmd: begin
          sum_d = rx_data;
          cmd_d = rx_data[2:0];
          case (rx_data)
            CMD_ILD, CMD_DLD:  state_d = StAddr;
            CMD_RUN, CMD_HALT: state_d = StCsum;
            default: begin
              state_d = StIdle;
              err_d   = 2'd1;
            end
          endcase
        end
        StAddr: begin
          sum_d   = csum_total;
          addr_d  = rx_data[FWIDTH-1:0];
          state_d = StLen;
        end
        StLen: begin
          sum_d      = csum_total;
          len_d      = rx_data;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          state_d    = StData;
        end
        StData: begin
          sum_d = csum_total;
          sh_d  = sh_next;
          if (byte_cnt_q == last_byte) begin
            byte_cnt_d = '0;
            // Loads are parsed but never written while the core is running.
            if (!run_q) begin
              if (is_dmem) begin
                dmem_we_d    = 1'b1;
                dmem_addr_d  = addr_q;
                dmem_wdata_d = sh_next[DWIDTH-1:0];
              end else begin
                imem_we_d    = 1'b1;
                imem_addr_d  = addr_q;
                imem_wdata_d = sh_next[IWIDTH-1:0];
              end
            end
            addr_d = addr_q + 1'b1;
            if (word_cnt_q == len_q) begin
              state_d = StCsum;
            end else begin
              word_cnt_d = word_cnt_q + 8'd1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        StCsum: begin
          state_d = StIdle;
          if (is_load && run_q) begin
            err_d = 2'd3;
          end else if (csum_total == 8'h00) begin
            err_d = 2'd0;
            ok_d  = 1'b1;
            if (cmd_q == CMD_RUN[2:0])  run_d = 1'b1;
            if (cmd_q == CMD_HALT[2:0]) run_d = 1'b0;
          end else begin
            err_d = 2'd2;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      cmd_q        <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      sum_q        <= '0;
      sh_q         <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      run_q        <= 1'b0;
      ok_q         <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= 1'b1;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      sum_q        <= sum_d;
      sh_q         <= sh_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      run_q        <= run_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready   = ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign cpu_run    = run_q;
  assign busy       = (state_q != StIdle);
  assign frame_ok   = ok_q;
  assign err_code   = err_q;

endmodule
